// File: rtl/synth_pkg.sv
// Shared defaults and state encoding for the wavetable oscillator.
// Imported by the interface, RAM and top-level oscillator.
package synth_pkg;

    localparam int SAMPLE_BITS_DEF = 16;
    localparam int CLIP_LEN_DEF    = 64;
    localparam int PHASE_BITS_DEF  = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SCALE,
        ST_PRESENT
    } osc_state_t;

endpackage

// File: rtl/wavetable_osc_if.sv
// Sample stream from the oscillator to the I2S serializer.
// master: drives smp_valid/smp_data, receives smp_ready.
interface wavetable_osc_if
    import synth_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
);
    logic                   smp_valid;
    logic                   smp_ready;
    logic [SAMPLE_BITS-1:0] smp_data;

    modport master (
        output smp_valid,
        output smp_data,
        input  smp_ready
    );

    modport slave (
        input  smp_valid,
        input  smp_data,
        output smp_ready
    );
endinterface

// File: rtl/wavetable_ram.sv
// Single-port-write, sync-read wavetable, read-before-write.
// Ports: clk, we/waddr/wdata write port, re/raddr/rdata read port.
module wavetable_ram
    import synth_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int CLIP_LEN    = CLIP_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(CLIP_LEN)-1:0] waddr,
    input  logic [SAMPLE_BITS-1:0]      wdata,
    input  logic                        re,
    input  logic [$clog2(CLIP_LEN)-1:0] raddr,
    output logic [SAMPLE_BITS-1:0]      rdata
);

    logic [SAMPLE_BITS-1:0] mem [CLIP_LEN];

    // Both updates are non-blocking, so a same-address
    // read returns the entry as it was before this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wavetable_osc.sv
// Phase-accumulator wavetable oscillator with gain and valid/ready output.
// Ports: mclk, rst_n, tbl_* write port, tune_*, gain, enable, phase_wrap, smp stream.
module wavetable_osc
    import synth_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int CLIP_LEN    = CLIP_LEN_DEF,
    parameter int PHASE_BITS  = PHASE_BITS_DEF
) (
    input  logic                        mclk,
    input  logic                        rst_n,
    input  logic                        tbl_we,
    input  logic [$clog2(CLIP_LEN)-1:0] tbl_addr,
    input  logic [SAMPLE_BITS-1:0]      tbl_wdata,
    input  logic [PHASE_BITS-1:0]       tune_word,
    input  logic                        tune_load,
    input  logic [3:0]                  gain,
    input  logic                        enable,
    output logic                        phase_wrap,
    wavetable_osc_if.master             smp
);

    localparam int ADDR_BITS = $clog2(CLIP_LEN);

    osc_state_t state;
    osc_state_t state_nxt;

    logic [PHASE_BITS-1:0]  phase;
    logic [PHASE_BITS-1:0]  incr;
    logic [PHASE_BITS-1:0]  incr_eff;
    logic [PHASE_BITS:0]    phase_sum;
    logic [SAMPLE_BITS-1:0] held;
    logic [SAMPLE_BITS-1:0] scaled;
    logic [SAMPLE_BITS-1:0] data_q;
    logic                   fire;
    logic                   ram_re;

    assign fire = smp.smp_valid && smp.smp_ready;

    // A load landing on the handshake edge is used by that addition.
    assign incr_eff  = tune_load ? tune_word : incr;
    assign phase_sum = {1'b0, phase} + {1'b0, incr_eff};

    assign smp.smp_data = data_q;

    wavetable_ram #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .CLIP_LEN    (CLIP_LEN)
    ) u_ram (
        .clk   (mclk),
        .we    (tbl_we),
        .waddr (tbl_addr),
        .wdata (tbl_wdata),
        .re    (ram_re),
        .raddr (phase[PHASE_BITS-1 -: ADDR_BITS]),
        .rdata (held)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_SCALE;
            ST_SCALE: state_nxt = ST_PRESENT;
            ST_PRESENT: begin
                // Never drop a presented sample; enable only
                // decides where to go once it is accepted.
                if (fire) begin
                    state_nxt = enable ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        smp.smp_valid = 1'b0;
        ram_re        = 1'b0;
        unique case (1'b1)
            (state == ST_FETCH):   ram_re        = 1'b1;
            (state == ST_PRESENT): smp.smp_valid = 1'b1;
            default: ;
        endcase
    end

    // Large gains saturate to pure sign so any SAMPLE_BITS behaves alike.
    always_comb begin
        scaled = '0;
        if (int'(gain) >= SAMPLE_BITS - 1) begin
            scaled = {SAMPLE_BITS{held[SAMPLE_BITS-1]}};
        end else begin
            scaled = $unsigned($signed(held) >>> gain);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            incr       <= '0;
            data_q     <= '0;
            phase_wrap <= 1'b0;
        end else begin
            phase_wrap <= fire && phase_sum[PHASE_BITS];
            if (tune_load) begin
                incr <= tune_word;
            end
            if (fire) begin
                phase <= phase_sum[PHASE_BITS-1:0];
            end
            if (state == ST_SCALE) begin
                data_q <= scaled;
            end
        end
    end

endmodule
